// File: rtl/mult8_pkg.sv
// Shared types, widths and step codes for the sequential 8x8 multiplier.
package mult8_pkg;
    localparam int OP_W   = 8;
    localparam int NIB_W  = 4;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [1:0] STEP_LL = 2'b00;
    localparam logic [1:0] STEP_HL = 2'b01;
    localparam logic [1:0] STEP_LH = 2'b10;
    localparam logic [1:0] STEP_HH = 2'b11;

    // Bit offset of each nibble partial product within the 16-bit product.
    function automatic logic [3:0] step_shift(input logic [1:0] s);
        case (s)
            STEP_LL: step_shift = 4'd0;
            STEP_HH: step_shift = 4'd8;
            default: step_shift = 4'd4;
        endcase
    endfunction
endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// Operand/result handshake bundle for mult8_seq_ctrl.
interface mult8_seq_ctrl_if;
    import mult8_pkg::*;
    logic                 in_valid;
    logic                 in_ready;
    logic [OP_W-1:0]      a_i;
    logic [OP_W-1:0]      b_i;
    logic [1:0]           step_o;
    logic [2*NIB_W-1:0]   pp_o;
    logic                 out_valid;
    logic                 out_ready;
    logic [PROD_W-1:0]    product_o;

    modport master (output in_valid, a_i, b_i, out_ready,
                    input  in_ready, step_o, pp_o, out_valid, product_o);
    modport slave  (input  in_valid, a_i, b_i, out_ready,
                    output in_ready, step_o, pp_o, out_valid, product_o);
endinterface

// File: rtl/mult4x4.sv
// Combinational 4x4 unsigned multiply, 8-bit result.
module mult4x4
    import mult8_pkg::*;
(
    input  logic [NIB_W-1:0]   x,
    input  logic [NIB_W-1:0]   y,
    output logic [2*NIB_W-1:0] p
);
    assign p = {{NIB_W{1'b0}}, x} * {{NIB_W{1'b0}}, y};
endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 multiplier: one nibble product per cycle, shifted and accumulated.
// Optional MULT8_SEQ_EARLY_ZERO_EN: zero operands skip CALC and go straight to DONE.
module mult8_seq_ctrl
    import mult8_pkg::*;
#(
    parameter int W = OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    mult8_seq_ctrl_if.slave   bus
);
    state_t                 state, state_nx;
    logic [W-1:0]           a_q, b_q;
    logic [1:0]             step;
    logic [PROD_W-1:0]      acc;
    logic                   ov;
    logic [NIB_W-1:0]       na, nb;
    logic [2*NIB_W-1:0]     pp;
    logic [PROD_W-1:0]      addend;
    logic                   zero_op;

    // step[0] selects the high multiplicand nibble, step[1] the high multiplier nibble.
    assign na = step[0] ? a_q[W-1:W/2] : a_q[W/2-1:0];
    assign nb = step[1] ? b_q[W-1:W/2] : b_q[W/2-1:0];

    mult4x4 u_mul (.x(na), .y(nb), .p(pp));

    assign addend  = {{(PROD_W-2*NIB_W){1'b0}}, pp} << step_shift(step);
    assign zero_op = (bus.a_i == '0) || (bus.b_i == '0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.in_valid) begin
`ifdef MULT8_SEQ_EARLY_ZERO_EN
                state_nx = zero_op ? DONE : CALC;
`else
                state_nx = CALC;
`endif
            end
            CALC: if (step == STEP_HH) state_nx = DONE;
            DONE: if (ov && bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            step  <= STEP_LL;
            acc   <= '0;
            ov    <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    a_q  <= bus.a_i;
                    b_q  <= bus.b_i;
                    acc  <= '0;
                    step <= STEP_LL;
                end
                CALC: begin
                    acc  <= acc + addend;
                    step <= step + 2'd1;
                    if (step == STEP_HH) ov <= 1'b1;
                end
                // Early-zero entry arrives with ov low; it rises one cycle later.
                DONE: ov <= !(ov && bus.out_ready);
                default: ov <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = ov;
    assign bus.product_o = acc;
    assign bus.step_o    = (state == CALC) ? step : 2'b00;
    assign bus.pp_o      = (state == CALC) ? pp : '0;

    logic unused_zero;
    assign unused_zero = zero_op;
endmodule
